// File: rtl/mac_frame_accumulator.sv
// Sums each frame of COUNT unsigned 6-bit products into one result.
// The result is held on a valid/ready port until the sink takes it.
module mac_frame_accumulator #(
  parameter int COUNT = 4,
  parameter int ACC_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [4:0]       beat_cnt
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  localparam logic [4:0] LAST_BEAT = 5'(COUNT - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             out_ovf_q, out_ovf_d;
  logic [4:0]       beat_q, beat_d;

  logic [ACC_W:0]   acc_ext;
  logic             carry;
  logic             accept;
  logic             last_beat;

  // One extra bit on the adder exposes the carry out of the accumulator.
  always_comb begin
    acc_ext   = {1'b0, acc_q} + {{(ACC_W - 5){1'b0}}, prod};
    carry     = acc_ext[ACC_W];
    accept    = in_valid && (state_q == ACCUM);
    last_beat = (beat_q == LAST_BEAT);
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    out_ovf_d = out_ovf_q;
    beat_d    = beat_q;

    if (flush) begin
      // Flush wins over both a same-cycle accept and a same-cycle out_ready.
      state_d = ACCUM;
      acc_d   = '0;
      ovf_d   = 1'b0;
      beat_d  = '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            if (last_beat) begin
              sum_d     = acc_ext[ACC_W-1:0];
              out_ovf_d = ovf_q | carry;
              acc_d     = '0;
              ovf_d     = 1'b0;
              beat_d    = '0;
              state_d   = DONE;
            end else begin
              acc_d  = acc_ext[ACC_W-1:0];
              ovf_d  = ovf_q | carry;
              beat_d = beat_q + 5'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
      out_ovf_q <= 1'b0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
      out_ovf_q <= out_ovf_d;
      beat_q    <= beat_d;
    end
  end

  // Every output comes straight from state or a register.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DONE);
    out_sum   = sum_q;
    out_ovf   = out_ovf_q;
    beat_cnt  = beat_q;
  end

endmodule
